// File: rtl/data_memory_responder_if.sv
// Request/response bundle between a load/store datapath and the data memory responder.
// Latency: none, wires only.
// Backpressure: req_ready stalls requests; resp_ready holds a pending response.
interface data_memory_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  // Requester side (datapath)
  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  // Responder side (memory)
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_memory_responder.sv
// Data memory responder: word RAM serving one load/store at a time over valid/ready.
// Latency: resp_valid rises WAIT_CYCLES+1 cycles after the request handshake cycle.
// Backpressure: req_ready is low until resp_ready takes the response; nothing is queued.
// Optional: define DMEM_MISALIGN_TRAP_EN to reject accesses with addr[1:0] != 0 via resp_err.
module data_memory_responder #(
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h10010000
) (
  input logic                    clk_i,
  input logic                    reset_i,
  data_memory_responder_if.slave bus_if
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  // Access port: driven either straight from the request (zero wait) or from the latched copy
  logic                  acc_en;
  logic                  acc_write;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic                  acc_misalign;
  logic [DEPTH_LOG2-1:0] acc_idx;

  logic [31:0] mem [DEPTH];

  // Addresses outside the window wrap modulo the memory size
  assign acc_idx = DEPTH_LOG2'((acc_addr - BASE_ADDR) >> 2);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign acc_misalign = (acc_addr[1:0] != 2'b00);
`else
  assign acc_misalign = 1'b0;
`endif

  assign bus_if.req_ready  = (state_q == ST_IDLE);
  assign bus_if.resp_valid = (state_q == ST_RESP);
  // rdata/err registers are zeroed whenever RESP is left, so they read 0 outside RESP
  assign bus_if.resp_rdata = rdata_q;
  assign bus_if.resp_err   = err_q;

  // Next-state logic: request capture, wait countdown, access and response hold
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    acc_en    = 1'b0;
    acc_write = wr_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus_if.req_valid) begin
          wr_d    = bus_if.req_write;
          addr_d  = bus_if.req_addr;
          wdata_d = bus_if.req_wdata;
          cnt_d   = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            acc_en    = 1'b1;
            acc_write = bus_if.req_write;
            acc_addr  = bus_if.req_addr;
            acc_wdata = bus_if.req_wdata;
            state_d   = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          acc_en  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus_if.resp_ready) begin
          rdata_d = 32'h0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (acc_en) begin
      if (acc_misalign) begin
        rdata_d = 32'h0;
        err_d   = 1'b1;
      end else begin
        // A store echoes its own data, so read-after-write needs no bypass here
        rdata_d = acc_write ? acc_wdata : mem[acc_idx];
        err_d   = 1'b0;
      end
    end
  end

  // Control and response registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Memory write on the edge entering RESP; a reset on that edge aborts the store
  always_ff @(posedge clk_i) begin
    if (!reset_i && acc_en && acc_write && !acc_misalign) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench: two responders (2 wait states and 0 wait states) on a shared clock/reset.
module tb_data_memory_responder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_memory_responder_if b2 ();
  data_memory_responder_if b0 ();

  data_memory_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(2), .BASE_ADDR(32'h10010000)) u_dut2 (
    .clk_i(clk), .reset_i(reset), .bus_if(b2)
  );
  data_memory_responder #(.DEPTH_LOG2(10), .WAIT_CYCLES(0), .BASE_ADDR(32'h10010000)) u_dut0 (
    .clk_i(clk), .reset_i(reset), .bus_if(b0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // One complete transaction on the 2-wait responder, starting at a negedge with it idle.
  // lat = cycles from the handshake cycle to the first cycle with resp_valid (20 = timeout).
  task automatic req2(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    b2.req_valid  = 1'b1;
    b2.req_write  = w;
    b2.req_addr   = a;
    b2.req_wdata  = d;
    b2.resp_ready = 1'b1;
    @(negedge clk);
    lat = 1;
    b2.req_valid = 1'b0;
    while (!b2.resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = b2.resp_rdata;
    er = b2.resp_err;
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (b2.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready2 got %b want 1", b2.req_ready); end
    n_cmp++; if (b2.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid2 got %b want 0", b2.resp_valid); end
    n_cmp++; if (b2.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata2 got %h want 0", b2.resp_rdata); end
    n_cmp++; if (b2.resp_err !== 1'b0) begin n_bad++; $display("FAIL rst_err2 got %b want 0", b2.resp_err); end
    n_cmp++; if (b0.req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_req_ready0 got %b want 1", b0.req_ready); end
    n_cmp++; if (b0.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid0 got %b want 0", b0.resp_valid); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_load;
    logic [31:0] rd;
    logic er;
    int lat;
    req2(1'b1, 32'h10010004, 32'hDEADBEEF, rd, er, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL st_latency got %0d want 3", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL st_echo got %h want deadbeef", rd); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL st_err got %b want 0", er); end
    n_cmp++; if (b2.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL idle_rdata got %h want 0", b2.resp_rdata); end
    req2(1'b0, 32'h10010004, 32'h0, rd, er, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL ld_latency got %0d want 3", lat); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL ld_data got %h want deadbeef", rd); end
  endtask

  task automatic test_zero_wait;
    b0.resp_ready = 1'b1;
    b0.req_valid  = 1'b1;
    b0.req_write  = 1'b1;
    b0.req_addr   = 32'h10010000;
    b0.req_wdata  = 32'h0F0F1234;
    n_cmp++; if (b0.req_ready !== 1'b1) begin n_bad++; $display("FAIL zw_hs1_ready got %b want 1", b0.req_ready); end
    @(negedge clk);
    n_cmp++; if (b0.resp_valid !== 1'b1) begin n_bad++; $display("FAIL zw_st_valid got %b want 1", b0.resp_valid); end
    n_cmp++; if (b0.resp_rdata !== 32'h0F0F1234) begin n_bad++; $display("FAIL zw_st_echo got %h want 0f0f1234", b0.resp_rdata); end
    n_cmp++; if (b0.req_ready !== 1'b0) begin n_bad++; $display("FAIL zw_resp_ready got %b want 0", b0.req_ready); end
    b0.req_write = 1'b0;
    @(negedge clk);
    n_cmp++; if (b0.req_ready !== 1'b1) begin n_bad++; $display("FAIL zw_hs2_ready got %b want 1", b0.req_ready); end
    n_cmp++; if (b0.resp_valid !== 1'b0) begin n_bad++; $display("FAIL zw_gap_valid got %b want 0", b0.resp_valid); end
    @(negedge clk);
    n_cmp++; if (b0.resp_valid !== 1'b1) begin n_bad++; $display("FAIL zw_ld_valid got %b want 1", b0.resp_valid); end
    n_cmp++; if (b0.resp_rdata !== 32'h0F0F1234) begin n_bad++; $display("FAIL zw_ld_data got %h want 0f0f1234", b0.resp_rdata); end
    b0.req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (b0.resp_valid !== 1'b0) begin n_bad++; $display("FAIL zw_done_valid got %b want 0", b0.resp_valid); end
  endtask

  task automatic test_backpressure;
    int lat;
    int extra;
    logic [31:0] rd;
    logic er;
    b2.resp_ready = 1'b0;
    b2.req_valid  = 1'b1;
    b2.req_write  = 1'b1;
    b2.req_addr   = 32'h10010010;
    b2.req_wdata  = 32'hCAFEF00D;
    @(negedge clk);
    lat = 1;
    while (!b2.resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL bp_latency got %0d want 3", lat); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (b2.resp_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid[%0d] got %b want 1", i, b2.resp_valid); end
      n_cmp++; if (b2.resp_rdata !== 32'hCAFEF00D) begin n_bad++; $display("FAIL bp_hold_rdata[%0d] got %h want cafef00d", i, b2.resp_rdata); end
      n_cmp++; if (b2.req_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_ready[%0d] got %b want 0", i, b2.req_ready); end
      @(negedge clk);
    end
    b2.req_valid  = 1'b0;
    b2.resp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (b2.resp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid got %b want 0", b2.resp_valid); end
    n_cmp++; if (b2.req_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got %b want 1", b2.req_ready); end
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (b2.resp_valid) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL bp_no_queue got %0d responses want 0", extra); end
    req2(1'b0, 32'h10010010, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL bp_readback got %h want cafef00d", rd); end
  endtask

  task automatic test_wrap;
    logic [31:0] rd;
    logic er;
    int lat;
    req2(1'b1, 32'h10010000, 32'h12345678, rd, er, lat);
    req2(1'b0, 32'h10011000, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL wrap_data got %h want 12345678", rd); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL wrap_err got %b want 0", er); end
  endtask

  task automatic test_reset_in_wait;
    logic [31:0] rd;
    logic er;
    int lat;
    req2(1'b1, 32'h10010008, 32'h11112222, rd, er, lat);
    b2.req_valid = 1'b1;
    b2.req_write = 1'b1;
    b2.req_addr  = 32'h10010008;
    b2.req_wdata = 32'hAAAA5555;
    @(negedge clk);
    b2.req_valid = 1'b0;
    @(negedge clk);
    // Last wait cycle: the store would commit on this edge if reset did not win
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (b2.req_ready !== 1'b1) begin n_bad++; $display("FAIL rw_ready got %b want 1", b2.req_ready); end
    n_cmp++; if (b2.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rw_valid got %b want 0", b2.resp_valid); end
    n_cmp++; if (b2.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rw_rdata got %h want 0", b2.resp_rdata); end
    n_cmp++; if (b2.resp_err !== 1'b0) begin n_bad++; $display("FAIL rw_err got %b want 0", b2.resp_err); end
    @(negedge clk);
    n_cmp++; if (b2.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rw_after_valid got %b want 0", b2.resp_valid); end
    req2(1'b0, 32'h10010008, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h11112222) begin n_bad++; $display("FAIL rw_old_data got %h want 11112222", rd); end
  endtask

  task automatic test_reset_in_resp;
    logic [31:0] rd;
    logic er;
    int lat;
    b2.resp_ready = 1'b0;
    b2.req_valid  = 1'b1;
    b2.req_write  = 1'b1;
    b2.req_addr   = 32'h1001000C;
    b2.req_wdata  = 32'h5A5A5A5A;
    @(negedge clk);
    b2.req_valid = 1'b0;
    lat = 1;
    while (!b2.resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL rr_latency got %0d want 3", lat); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (b2.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rr_dropped got %b want 0", b2.resp_valid); end
    req2(1'b0, 32'h1001000C, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h5A5A5A5A) begin n_bad++; $display("FAIL rr_committed got %h want 5a5a5a5a", rd); end
  endtask

  task automatic test_misalign;
    logic [31:0] rd;
    logic er;
    int lat;
    req2(1'b0, 32'h10010002, 32'h0, rd, er, lat);
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL mis_latency got %0d want 3", lat); end
`ifdef DMEM_MISALIGN_TRAP_EN
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL mis_err got %b want 1", er); end
    n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mis_rdata got %h want 0", rd); end
`else
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL mis_err got %b want 0", er); end
    n_cmp++; if (rd !== 32'h12345678) begin n_bad++; $display("FAIL mis_rdata got %h want 12345678", rd); end
`endif
  endtask

  initial begin
    reset         = 1'b1;
    b2.req_valid  = 1'b0;
    b2.req_write  = 1'b0;
    b2.req_addr   = 32'h0;
    b2.req_wdata  = 32'h0;
    b2.resp_ready = 1'b1;
    b0.req_valid  = 1'b0;
    b0.req_write  = 1'b0;
    b0.req_addr   = 32'h0;
    b0.req_wdata  = 32'h0;
    b0.resp_ready = 1'b1;
    test_reset();
    test_store_load();
    test_zero_wait();
    test_backpressure();
    test_wrap();
    test_reset_in_wait();
    test_reset_in_resp();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10; log2 of the number of 32-bit words stored.
REQ-002 Parameter WAIT_CYCLES, default 2; wait states inserted between request acceptance and the memory access (0..15).
REQ-003 Parameter BASE_ADDR, default 32'h10010000; byte address mapped to word index 0.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  1  requester presents a load/store request.
REQ-007 req_ready  out  1  responder can accept a request this cycle.
REQ-008 req_write  in  1  1 = store, 0 = load; sampled at handshake.
REQ-009 req_addr  in  32  byte address (the datapath's ALU result); sampled at handshake.
REQ-010 req_wdata  in  32  store data (the datapath's second register operand); sampled at handshake.
REQ-011 resp_valid  out  1  response available.
REQ-012 resp_ready  in  1  requester accepts the response.
REQ-013 resp_rdata  out  32  load data, or echo of the stored word for stores.
REQ-014 resp_err  out  1  misaligned-access flag; constant 0 when MISALIGN_TRAP_EN is undefined.

Function
REQ-015 FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE, resp_valid = 1 only in RESP.
REQ-016 IDLE: on req_valid & req_ready, latch write/addr/wdata, load wait counter with WAIT_CYCLES, go to WAIT; if WAIT_CYCLES = 0, perform the access and go directly to RESP.
REQ-017 WAIT: decrement the counter each cycle; in the cycle it reads 1, perform the access and go to RESP.
REQ-018 Access: index = ((addr - BASE_ADDR) >> 2) modulo 2^DEPTH_LOG2; out-of-range addresses wrap, no error.
REQ-019 Store: write wdata to mem[index] on the RESP transition edge; resp_rdata = stored word.
REQ-020 Load: resp_rdata = mem[index] as captured on the RESP transition edge.
REQ-021 RESP: hold resp_valid, resp_rdata and resp_err stable until resp_ready = 1, then go to IDLE the next cycle.
REQ-022 Latency: handshake at edge N -> resp_valid high from edge N+WAIT_CYCLES+1; maximum throughput is one request per WAIT_CYCLES+2 cycles when resp_ready is tied high.
REQ-023 req_valid outside IDLE is ignored; the request is not queued.
REQ-024 resp_ready outside RESP has no effect.
REQ-025 A load from an address stored by the immediately preceding request returns the new data.
REQ-026 resp_rdata = 0 and resp_err = 0 whenever resp_valid = 0.

Reset
REQ-027 reset forces IDLE, counter 0, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0.
REQ-028 Reset in WAIT discards the pending request; the store is not committed.
REQ-029 Reset in RESP drops the response; a store already committed remains in memory.
REQ-030 Memory contents are not cleared by reset.

Configuration
REQ-031 Macro DMEM_MISALIGN_TRAP_EN is defined: a request with addr[1:0] != 0 performs no memory access, returns resp_rdata = 0 and resp_err = 1 with normal latency.
REQ-032 Macro DMEM_MISALIGN_TRAP_EN is undefined: addr[1:0] is ignored, the access proceeds word-aligned, and resp_err is tied to 0.

Verification
REQ-033 Reset, then store 32'hDEADBEEF to 32'h10010004 and load the same address (WAIT_CYCLES = 2) -> load resp_rdata = 32'hDEADBEEF; resp_valid rises 3 cycles after each handshake.
REQ-034 WAIT_CYCLES = 0: store then load 32'h10010000, with resp_ready tied high -> resp_valid high the cycle after each handshake; one request per 2 cycles.
REQ-035 Hold resp_ready = 0 for 5 cycles in RESP, and hold req_valid = 1 throughout -> resp_valid and resp_rdata stable, req_ready = 0, no second request accepted.
REQ-036 Store 32'h12345678 to 32'h10010000, then load 32'h10011000 (DEPTH_LOG2 = 10) -> wraps to index 0, rdata = 32'h12345678.
REQ-037 Assert reset in WAIT of a store of 32'hAAAA5555 to 32'h10010008, then load that address -> old contents returned, and outputs are at reset values in the cycle after reset.
REQ-038 Load from 32'h10010002 -> with the macro: resp_err = 1, rdata = 0; without it: resp_err = 0, rdata = word at 32'h10010000.
